hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk_i is the clock, rst_i the reset; all state updates on posedge clk_i.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- idex_memread_i  in  1  ID/EX stage holds a load
- idex_regwrite_i  in  1  ID/EX stage writes a register
- idex_rt_i  in  5  ID/EX rt field
- idex_dst_i  in  5  ID/EX destination register, after RegDst select
- ifid_rs_i  in  5  IF/ID rs field
- ifid_rt_i  in  5  IF/ID rt field
- ifid_uses_rt_i  in  1  IF/ID instruction reads rt
- ifid_is_branch_i  in  1  IF/ID holds a branch, compared in ID
- branch_taken_i  in  1  ID branch compare result
- dmem_busy_i  in  1  data memory not ready
- cnt_clr_i  in  1  clear statistics counters
- pc_write_o  out  1  PC load enable
- ifid_write_o  out  1  IF/ID load enable
- ifid_flush_o  out  1  IF/ID load NOP
- idex_write_o  out  1  ID/EX load enable
- idex_bubble_o  out  1  zero WB/M/EX controls entering ID/EX
- exmem_write_o  out  1  EX/MEM and MEM/WB load enable
- state_o  out  1  0=RUN, 1=BR_LD
- lu_cnt_o  out  16  hazard bubble count
- mem_cnt_o  out  16  memory freeze count
- flush_cnt_o  out  16  branch flush count

Function
REQ-003 SHALL define H_LU = idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | (ifid_uses_rt_i & idex_rt_i==ifid_rt_i)).
REQ-004 SHALL define H_BR = ifid_is_branch_i & idex_regwrite_i & (idex_dst_i!=0) & (idex_dst_i==ifid_rs_i | idex_dst_i==ifid_rt_i).
REQ-005 SHALL compute all enable/flush/bubble outputs combinationally from state and current inputs (zero latency).
REQ-006 SHALL use priority: rst_i > dmem_busy_i > state BR_LD > (H_LU|H_BR) > branch_taken_i > normal.
REQ-007 Freeze (dmem_busy_i=1, any state): pc/ifid/idex/exmem write=0, flush=0, bubble=0; state holds.
REQ-008 BR_LD, not busy: pc_write=0, ifid_write=0, bubble=1, idex/exmem write=1, flush=0; branch_taken_i ignored; next state RUN.
REQ-009 RUN with H_LU|H_BR: pc_write=0, ifid_write=0, bubble=1, flush=0, idex/exmem write=1; next state BR_LD if H_BR & idex_memread_i, else RUN.
REQ-010 RUN, no hazard, branch_taken_i=1: all writes=1, ifid_flush=1, bubble=0; state RUN.
REQ-011 RUN, normal: all writes=1, flush=0, bubble=0.
REQ-012 Result: load-use = 1 bubble; ALU-to-branch = 1 bubble; load-to-branch = 2 consecutive bubbles; freeze cycles extend any sequence without losing it.
REQ-013 lu_cnt_o +1 per cycle with bubble=1; mem_cnt_o +1 per freeze cycle; flush_cnt_o +1 per cycle with ifid_flush=1.
REQ-014 Counters SHALL saturate at 0xFFFF and not wrap.
REQ-015 cnt_clr_i=1 SHALL zero all counters next edge, with priority over same-cycle increment.

Reset
REQ-016 rst_i=1 at posedge: state RUN, all counters 0.
REQ-017 While rst_i=1: pc_write=0, ifid_write=0, ifid_flush=1, bubble=1, idex_write=1, exmem_write=1.
REQ-018 Reset asserted mid-BR_LD or mid-freeze SHALL abandon the sequence; first cycle after reset is RUN.

Verification
REQ-019 Load rt=5, IF/ID rs=5 -> exactly 1 cycle pc_write=0/bubble=1, then normal; lu_cnt_o=1.
REQ-020 Load rt=0, IF/ID rs=0 -> no stall; lu_cnt_o=0.
REQ-021 Load dst=8, branch in IF/ID using rt=8 -> 2 bubble cycles, state_o 0,1,0; lu_cnt_o=2.
REQ-022 Load-to-branch with dmem_busy_i=1 for 3 cycles during BR_LD -> 3 frozen cycles, state_o stays 1, then 1 bubble; mem_cnt_o=3, lu_cnt_o=2.
REQ-023 branch_taken_i=1 with H_BR=1 -> no flush that cycle; flush next cycle after hazard clears; flush_cnt_o=1.
REQ-024 Preload lu_cnt_o=0xFFFF, force bubble -> stays 0xFFFF; cnt_clr_i with bubble -> 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle for the hazard controller
// Purpose: groups the pipeline stage fields, branch/memory status and the
//          stall/flush/bubble controls exchanged with hazard_ctrl.
// Ports (modports):
//   master - pipeline side: drives stage fields and status, receives controls
//   slave  - hazard_ctrl side: receives stage fields and status, drives controls
interface hazard_ctrl_if;
    logic        idex_memread_i;
    logic        idex_regwrite_i;
    logic [4:0]  idex_rt_i;
    logic [4:0]  idex_dst_i;
    logic [4:0]  ifid_rs_i;
    logic [4:0]  ifid_rt_i;
    logic        ifid_uses_rt_i;
    logic        ifid_is_branch_i;
    logic        branch_taken_i;
    logic        dmem_busy_i;
    logic        cnt_clr_i;
    logic        pc_write_o;
    logic        ifid_write_o;
    logic        ifid_flush_o;
    logic        idex_write_o;
    logic        idex_bubble_o;
    logic        exmem_write_o;
    logic        state_o;
    logic [15:0] lu_cnt_o;
    logic [15:0] mem_cnt_o;
    logic [15:0] flush_cnt_o;

    modport master (
        output idex_memread_i, idex_regwrite_i, idex_rt_i, idex_dst_i,
               ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, ifid_is_branch_i,
               branch_taken_i, dmem_busy_i, cnt_clr_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
               idex_bubble_o, exmem_write_o, state_o,
               lu_cnt_o, mem_cnt_o, flush_cnt_o
    );

    modport slave (
        input  idex_memread_i, idex_regwrite_i, idex_rt_i, idex_dst_i,
               ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, ifid_is_branch_i,
               branch_taken_i, dmem_busy_i, cnt_clr_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
               idex_bubble_o, exmem_write_o, state_o,
               lu_cnt_o, mem_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard detection, stall/flush control and statistics
// Purpose: detects load-use and ID-stage branch operand hazards, freezes the
//          pipeline while data memory is busy, flushes IF/ID on taken branches
//          and counts bubbles, freeze cycles and flushes.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   bus    - hazard_ctrl_if.slave: stage fields/status in, enables/flush/bubble,
//            state and saturating 16-bit statistics counters out
module hazard_ctrl (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_ctrl_if.slave  bus
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_BR_LD = 1'b1;

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       h_lu;
    logic       h_br;
    logic       freeze;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_write;
    logic       idex_bubble;
    logic       exmem_write;
    logic [15:0] lu_cnt_q;
    logic [15:0] mem_cnt_q;
    logic [15:0] flush_cnt_q;

    // Load in EX feeding the instruction in ID; register 0 never creates a dependency.
    assign h_lu = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
                  ((bus.idex_rt_i == bus.ifid_rs_i) ||
                   (bus.ifid_uses_rt_i && (bus.idex_rt_i == bus.ifid_rt_i)));

    // Branch compared in ID needs a result still sitting in EX.
    assign h_br = bus.ifid_is_branch_i && bus.idex_regwrite_i && (bus.idex_dst_i != 5'd0) &&
                  ((bus.idex_dst_i == bus.ifid_rs_i) || (bus.idex_dst_i == bus.ifid_rt_i));

    assign freeze = !rst_i && bus.dmem_busy_i;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;
        exmem_write = 1'b1;
        state_d     = ST_RUN;
        if (rst_i) begin
            // Hold fetch, and push NOPs into IF/ID and ID/EX so the pipe drains clean.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (bus.dmem_busy_i) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            state_d     = state_q;
        end else if (state_q == ST_BR_LD) begin
            // Second bubble of load-to-branch: the load is now in MEM, one more cycle to WB.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (h_lu || h_br) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = (h_br && bus.idex_memread_i) ? ST_BR_LD : ST_RUN;
        end else if (bus.branch_taken_i) begin
            ifid_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            lu_cnt_q    <= 16'd0;
            mem_cnt_q   <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (bus.cnt_clr_i) begin
                lu_cnt_q    <= 16'd0;
                mem_cnt_q   <= 16'd0;
                flush_cnt_q <= 16'd0;
            end else begin
                if (idex_bubble && (lu_cnt_q != 16'hFFFF))
                    lu_cnt_q <= lu_cnt_q + 16'd1;
                if (freeze && (mem_cnt_q != 16'hFFFF))
                    mem_cnt_q <= mem_cnt_q + 16'd1;
                if (ifid_flush && (flush_cnt_q != 16'hFFFF))
                    flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign bus.pc_write_o    = pc_write;
    assign bus.ifid_write_o  = ifid_write;
    assign bus.ifid_flush_o  = ifid_flush;
    assign bus.idex_write_o  = idex_write;
    assign bus.idex_bubble_o = idex_bubble;
    assign bus.exmem_write_o = exmem_write;
    assign bus.state_o       = state_q;
    assign bus.lu_cnt_o      = lu_cnt_q;
    assign bus.mem_cnt_o     = mem_cnt_q;
    assign bus.flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    logic mst;
    logic [6:0] exp_q[$];

    hazard_ctrl_if bus ();

    hazard_ctrl u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, state}
    function automatic logic [6:0] exp_ctrl();
        logic hl;
        logic hb;
        hl = bus.idex_memread_i && (bus.idex_rt_i != 0) &&
             (bus.idex_rt_i == bus.ifid_rs_i || (bus.ifid_uses_rt_i && bus.idex_rt_i == bus.ifid_rt_i));
        hb = bus.ifid_is_branch_i && bus.idex_regwrite_i && (bus.idex_dst_i != 0) &&
             (bus.idex_dst_i == bus.ifid_rs_i || bus.idex_dst_i == bus.ifid_rt_i);
        if (rst)                   return {6'b001111, mst};
        if (bus.dmem_busy_i)       return {6'b000000, mst};
        if (mst)                   return {6'b000111, mst};
        if (hl || hb)              return {6'b000111, mst};
        if (bus.branch_taken_i)    return {6'b111101, mst};
        return {6'b110101, mst};
    endfunction

    function automatic logic next_state();
        logic hb;
        hb = bus.ifid_is_branch_i && bus.idex_regwrite_i && (bus.idex_dst_i != 0) &&
             (bus.idex_dst_i == bus.ifid_rs_i || bus.idex_dst_i == bus.ifid_rt_i);
        if (rst)             return 1'b0;
        if (bus.dmem_busy_i) return mst;
        if (mst)             return 1'b0;
        if (exp_ctrl() == {6'b000111, 1'b0}) return hb && bus.idex_memread_i;
        return 1'b0;
    endfunction

    task automatic idle();
        rst                  = 1'b0;
        bus.idex_memread_i   = 1'b0;
        bus.idex_regwrite_i  = 1'b0;
        bus.idex_rt_i        = 5'd0;
        bus.idex_dst_i       = 5'd0;
        bus.ifid_rs_i        = 5'd0;
        bus.ifid_rt_i        = 5'd0;
        bus.ifid_uses_rt_i   = 1'b0;
        bus.ifid_is_branch_i = 1'b0;
        bus.branch_taken_i   = 1'b0;
        bus.dmem_busy_i      = 1'b0;
        bus.cnt_clr_i        = 1'b0;
    endtask

    // One clock: inputs already driven, expectation queued, outputs popped and checked at negedge.
    task automatic step(input string name);
        logic [6:0] act;
        logic [6:0] exp;
        logic       nxt;
        exp_q.push_back(exp_ctrl());
        nxt = next_state();
        @(negedge clk);
        act = {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o, bus.idex_write_o,
               bus.idex_bubble_o, bus.exmem_write_o, bus.state_o};
        exp = exp_q.pop_front();
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s ctrl {pc,ifid,flush,idex,bub,exmem,st} got %b want %b", name, act, exp);
        else
            pass_cnt++;
        @(posedge clk);
        mst = nxt;
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step("reset_ctrl");
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total_cnt++;
        if ({bus.state_o, bus.lu_cnt_o, bus.mem_cnt_o, bus.flush_cnt_o} !== 49'd0)
            $display("FAIL reset_state got st=%b lu=%h mem=%h fl=%h want all 0",
                     bus.state_o, bus.lu_cnt_o, bus.mem_cnt_o, bus.flush_cnt_o);
        else
            pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        do_reset();
        bus.idex_memread_i = 1'b1; bus.idex_rt_i = 5'd5; bus.ifid_rs_i = 5'd5;
        step("lu_bubble");
        idle();
        step("lu_after");
        total_cnt++;
        if (bus.lu_cnt_o !== 16'd1) $display("FAIL lu_cnt got %0d want 1", bus.lu_cnt_o);
        else pass_cnt++;
    endtask

    task automatic test_r0();
        do_reset();
        bus.idex_memread_i = 1'b1;
        step("r0_no_stall");
        idle();
        total_cnt++;
        if (bus.lu_cnt_o !== 16'd0) $display("FAIL r0_lu_cnt got %0d want 0", bus.lu_cnt_o);
        else pass_cnt++;
    endtask

    task automatic load_branch_setup();
        bus.idex_memread_i = 1'b1; bus.idex_regwrite_i = 1'b1;
        bus.idex_rt_i = 5'd8; bus.idex_dst_i = 5'd8;
        bus.ifid_is_branch_i = 1'b1; bus.ifid_rs_i = 5'd2; bus.ifid_rt_i = 5'd8;
        bus.ifid_uses_rt_i = 1'b1;
    endtask

    task automatic test_load_branch();
        do_reset();
        load_branch_setup();
        step("lb_bub1");
        idle(); bus.ifid_is_branch_i = 1'b1; bus.branch_taken_i = 1'b1;
        total_cnt++;
        if (bus.state_o !== 1'b1) $display("FAIL lb_state got %b want 1", bus.state_o);
        else pass_cnt++;
        step("lb_bub2_ignores_taken");
        idle();
        step("lb_normal");
        total_cnt++;
        if (bus.lu_cnt_o !== 16'd2 || bus.flush_cnt_o !== 16'd0)
            $display("FAIL lb_cnt got lu=%0d fl=%0d want lu=2 fl=0", bus.lu_cnt_o, bus.flush_cnt_o);
        else pass_cnt++;
    endtask

    task automatic test_freeze_brld();
        do_reset();
        load_branch_setup();
        step("fz_bub1");
        idle(); bus.dmem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) step("fz_freeze");
        idle();
        step("fz_bub2");
        step("fz_normal");
        total_cnt++;
        if (bus.mem_cnt_o !== 16'd3 || bus.lu_cnt_o !== 16'd2)
            $display("FAIL fz_cnt got mem=%0d lu=%0d want mem=3 lu=2", bus.mem_cnt_o, bus.lu_cnt_o);
        else pass_cnt++;
    endtask

    task automatic test_taken_hazard();
        do_reset();
        bus.idex_regwrite_i = 1'b1; bus.idex_dst_i = 5'd3; bus.ifid_rs_i = 5'd3;
        bus.ifid_is_branch_i = 1'b1; bus.branch_taken_i = 1'b1;
        step("bt_hazard_no_flush");
        idle(); bus.ifid_is_branch_i = 1'b1; bus.ifid_rs_i = 5'd3; bus.branch_taken_i = 1'b1;
        step("bt_flush");
        idle();
        step("bt_normal");
        total_cnt++;
        if (bus.flush_cnt_o !== 16'd1 || bus.lu_cnt_o !== 16'd1)
            $display("FAIL bt_cnt got fl=%0d lu=%0d want fl=1 lu=1", bus.flush_cnt_o, bus.lu_cnt_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_branch_setup();
        step("rm_enter_brld");
        idle(); rst = 1'b1;
        step("rm_reset_in_brld");
        idle();
        step("rm_run_after");
        load_branch_setup();
        step("rm_enter_again");
        idle(); bus.dmem_busy_i = 1'b1;
        step("rm_freeze");
        rst = 1'b1;
        step("rm_reset_in_freeze");
        idle();
        total_cnt++;
        if (bus.state_o !== 1'b0 || bus.mem_cnt_o !== 16'd0)
            $display("FAIL rm_state got st=%b mem=%0d want st=0 mem=0", bus.state_o, bus.mem_cnt_o);
        else pass_cnt++;
        step("rm_normal");
    endtask

    task automatic test_saturation();
        do_reset();
        bus.idex_memread_i = 1'b1; bus.idex_rt_i = 5'd7; bus.ifid_rs_i = 5'd7;
        repeat (65535) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.lu_cnt_o !== 16'hFFFF) $display("FAIL sat_reach got %h want ffff", bus.lu_cnt_o);
        else pass_cnt++;
        step("sat_bubble");
        total_cnt++;
        if (bus.lu_cnt_o !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", bus.lu_cnt_o);
        else pass_cnt++;
        bus.cnt_clr_i = 1'b1;
        step("sat_clr_bubble");
        total_cnt++;
        if (bus.lu_cnt_o !== 16'd0) $display("FAIL sat_clr got %h want 0", bus.lu_cnt_o);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            rst                  = ($urandom_range(0, 29) == 0);
            bus.idex_memread_i   = $urandom_range(0, 1) != 0;
            bus.idex_regwrite_i  = $urandom_range(0, 1) != 0;
            bus.idex_rt_i        = 5'($urandom_range(0, 3));
            bus.idex_dst_i       = 5'($urandom_range(0, 3));
            bus.ifid_rs_i        = 5'($urandom_range(0, 3));
            bus.ifid_rt_i        = 5'($urandom_range(0, 3));
            bus.ifid_uses_rt_i   = $urandom_range(0, 1) != 0;
            bus.ifid_is_branch_i = $urandom_range(0, 1) != 0;
            bus.branch_taken_i   = $urandom_range(0, 1) != 0;
            bus.dmem_busy_i      = ($urandom_range(0, 4) == 0);
            bus.cnt_clr_i        = ($urandom_range(0, 19) == 0);
            step("rand_ctrl");
        end
        idle();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        mst       = 1'b0;
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_r0();
        test_load_branch();
        test_freeze_brld();
        test_taken_hazard();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
